// File: rtl/bp_cfg_loader.sv
// Post-reset configuration sequencer: writes freeze/core-id/cce-mode to every
// core over a single-outstanding config link, then unfreezes all cores.
module bp_cfg_loader #(
  parameter int num_core_p       = 2,
  parameter int cfg_addr_width_p = 16,
  parameter int cfg_data_width_p = 32,
  parameter int cce_mode_width_p = 1,
  localparam int lg_num_core_lp  = (num_core_p > 1) ? $clog2(num_core_p) : 1
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic [cce_mode_width_p-1:0] cce_mode_i,
  output logic                        cfg_v_o,
  input  logic                        cfg_ready_i,
  output logic [lg_num_core_lp-1:0]   cfg_core_o,
  output logic [cfg_addr_width_p-1:0] cfg_addr_o,
  output logic [cfg_data_width_p-1:0] cfg_data_o,
  input  logic                        cfg_ack_v_i,
  output logic                        done_o,
  output logic                        err_o
);

  typedef enum logic [1:0] {e_reset, e_send, e_wait_ack, e_done} state_e;

  localparam logic [lg_num_core_lp-1:0] last_core_lp = lg_num_core_lp'(num_core_p - 1);

  state_e                    state_r, state_n;
  logic                      phase_r, phase_n;
  logic [lg_num_core_lp-1:0] core_r, core_n;
  logic [1:0]                reg_r, reg_n;
  logic                      err_r;
  logic                      freeze_bit;

  // Phase 0 freezes cores, phase 1 releases them.
  assign freeze_bit = ~phase_r;
  assign err_o      = err_r;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r <= e_reset;
      phase_r <= 1'b0;
      core_r  <= '0;
      reg_r   <= '0;
      err_r   <= 1'b0;
    end else begin
      state_r <= state_n;
      phase_r <= phase_n;
      core_r  <= core_n;
      reg_r   <= reg_n;
      if (cfg_ack_v_i && (state_r != e_wait_ack)) begin
        err_r <= 1'b1;
      end
    end
  end

  always_comb begin
    state_n    = state_r;
    phase_n    = phase_r;
    core_n     = core_r;
    reg_n      = reg_r;
    cfg_v_o    = 1'b0;
    cfg_core_o = '0;
    cfg_addr_o = '0;
    cfg_data_o = '0;
    done_o     = 1'b0;

    case (state_r)
      e_reset: begin
        state_n = e_send;
      end

      e_send: begin
        cfg_v_o    = 1'b1;
        cfg_core_o = core_r;
        cfg_addr_o = cfg_addr_width_p'(reg_r);
        case (reg_r)
          2'd0:    cfg_data_o = cfg_data_width_p'(freeze_bit);
          2'd1:    cfg_data_o = cfg_data_width_p'(core_r);
          default: cfg_data_o = cfg_data_width_p'(cce_mode_i);
        endcase
        if (cfg_ready_i) begin
          state_n = e_wait_ack;
        end
      end

      e_wait_ack: begin
        if (cfg_ack_v_i) begin
          state_n = e_send;
          if (!phase_r) begin
            if (reg_r == 2'd2) begin
              reg_n = '0;
              if (core_r == last_core_lp) begin
                core_n  = '0;
                phase_n = 1'b1;
              end else begin
                core_n = core_r + lg_num_core_lp'(1);
              end
            end else begin
              reg_n = reg_r + 2'd1;
            end
          end else if (core_r == last_core_lp) begin
            state_n = e_done;
          end else begin
            core_n = core_r + lg_num_core_lp'(1);
          end
        end
      end

      e_done: begin
        done_o = 1'b1;
      end

      default: begin
        state_n = e_reset;
      end
    endcase
  end

endmodule
